// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types for the multi-precision ALU sequencer
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_LSL = 3'b110,
    OP_LSR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } alu_seq_state_e;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } flags_t;

  function automatic logic is_shift(alu_op_e op);
    return (op == OP_LSL) || (op == OP_LSR);
  endfunction

endpackage

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - drives an external 8-bit ALU word by word to run WORDS*WIDTH-bit ops
// and keeps the persistent C/Z/N/V status register.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [WIDTH*WORDS-1:0]   req_a,
  input  logic [WIDTH*WORDS-1:0]   req_b,
  input  logic                     req_update_flags,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH*WORDS-1:0]   resp_y,
  output logic                     flag_c,
  output logic                     flag_z,
  output logic                     flag_n,
  output logic                     flag_v,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_op,
  output logic                     alu_c_in,
  output logic                     alu_en,
  output logic                     alu_update_flags,
  input  logic [WIDTH-1:0]         alu_y,
  input  logic                     alu_c_out,
  input  logic                     alu_v
);

  localparam int N   = WIDTH * WORDS;
  localparam int SHW = $clog2(N);
  localparam int WW  = $clog2(WORDS);

  alu_seq_state_e   state_q, state_d;
  alu_op_e          op_q, op_d;
  logic [N-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic             upd_q, upd_d, carry_q, carry_d;
  logic [SHW-1:0]   pass_q, pass_d;
  logic [WW-1:0]    step_q, step_d, word_idx;
  flags_t           flags_q, flags_d, flags_new;
  logic             shifting, step_last, op_last, zero_shift, shift_in, shift_out;
  logic [WIDTH-1:0] word_a, word_b, word_res;

  assign shifting   = is_shift(op_q);
  assign word_idx   = (op_q == OP_LSR) ? (WW'(WORDS - 1) - step_q) : step_q;
  assign word_a     = a_q[word_idx*WIDTH +: WIDTH];
  assign word_b     = b_q[word_idx*WIDTH +: WIDTH];
  assign step_last  = (step_q == WW'(WORDS - 1));
  assign op_last    = step_last && (!shifting || (pass_q == SHW'(1)));
  assign zero_shift = is_shift(alu_op_e'(req_op)) && (req_b[SHW-1:0] == '0);
  // Bit carried across word boundaries within one shift pass; nothing enters at the start of a pass.
  assign shift_in   = (step_q == '0) ? 1'b0 : carry_q;
  assign shift_out  = (op_q == OP_LSL) ? word_a[WIDTH-1] : word_a[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = zero_shift ? ST_DONE : ST_EXEC;
      ST_EXEC: if (op_last) state_d = ST_DONE;
      ST_DONE: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready        = (state_q == ST_IDLE) && !rst;
    resp_valid       = (state_q == ST_DONE);
    alu_en           = 1'b0;
    alu_update_flags = 1'b0;
    alu_op           = 3'b000;
    alu_a            = '0;
    alu_b            = '0;
    alu_c_in         = 1'b0;
    if (state_q == ST_EXEC) begin
      alu_en           = 1'b1;
      alu_update_flags = 1'b1;
      alu_op           = op_q;
      alu_a            = word_a;
      alu_b            = shifting ? WIDTH'(1) : word_b;
      if (op_q == OP_ADD || op_q == OP_SUB) begin
        alu_c_in = (step_q == '0) ? (op_q == OP_SUB) : carry_q;
      end
    end
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    upd_d     = upd_q;
    pass_d    = pass_q;
    step_d    = step_q;
    carry_d   = carry_q;
    res_d     = res_q;
    flags_d   = flags_q;
    flags_new = '0;
    word_res  = alu_y;
    if (state_q == ST_IDLE && req_valid) begin
      op_d    = alu_op_e'(req_op);
      a_d     = req_a;
      b_d     = req_b;
      upd_d   = req_update_flags;
      pass_d  = req_b[SHW-1:0];
      step_d  = '0;
      carry_d = 1'b0;
      res_d   = zero_shift ? req_a : '0;
      if (zero_shift && req_update_flags) begin
        flags_new.z = ~|req_a;
        flags_new.n = req_a[N-1];
        flags_d     = flags_new;
      end
    end else if (state_q == ST_EXEC) begin
      case (op_q)
        OP_LSL:  word_res = alu_y | {{(WIDTH-1){1'b0}}, shift_in};
        OP_LSR:  word_res = alu_y | {shift_in, {(WIDTH-1){1'b0}}};
        default: word_res = alu_y;
      endcase
      res_d[word_idx*WIDTH +: WIDTH] = word_res;
      carry_d = shifting ? shift_out : alu_c_out;
      if (step_last) begin
        step_d = '0;
        // A finished pass becomes the operand of the next one.
        if (shifting) begin
          a_d    = res_d;
          pass_d = pass_q - SHW'(1);
        end
      end else begin
        step_d = step_q + WW'(1);
      end
      if (op_last && upd_q) begin
        flags_new.c = (op_q == OP_ADD || op_q == OP_SUB) ? alu_c_out : (shifting ? shift_out : 1'b0);
        flags_new.v = (op_q == OP_ADD || op_q == OP_SUB) ? alu_v : 1'b0;
        flags_new.z = ~|res_d;
        flags_new.n = res_d[N-1];
        flags_d     = flags_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      upd_q   <= 1'b0;
      pass_q  <= '0;
      step_q  <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      upd_q   <= upd_d;
      pass_q  <= pass_d;
      step_q  <= step_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign resp_y = res_q;
  assign flag_c = flags_q.c;
  assign flag_z = flags_q.z;
  assign flag_n = flags_q.n;
  assign flag_v = flags_q.v;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq with a behavioural 8-bit ALU beside it
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [15:0] req_a = '0, req_b = '0;
  logic        req_update_flags = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [15:0] resp_y;
  logic        flag_c, flag_z, flag_n, flag_v;
  logic [7:0]  alu_a, alu_b, alu_y;
  logic [2:0]  alu_op;
  logic        alu_c_in, alu_en, alu_update_flags, alu_c_out, alu_v;
  logic [3:0]  flags;
  logic [8:0]  alu_s;

  alu_seq #(.WIDTH(8), .WORDS(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_update_flags(req_update_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_y(resp_y),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c_in(alu_c_in),
    .alu_en(alu_en), .alu_update_flags(alu_update_flags),
    .alu_y(alu_y), .alu_c_out(alu_c_out), .alu_v(alu_v)
  );

  assign flags = {flag_c, flag_z, flag_n, flag_v};

  always #5 clk = ~clk;

  // The external combinational ALU.
  always_comb begin
    alu_s     = '0;
    alu_y     = '0;
    alu_c_out = 1'b0;
    alu_v     = 1'b0;
    case (alu_op)
      3'd0: begin
        alu_s = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_c_in};
        alu_y = alu_s[7:0]; alu_c_out = alu_s[8];
        alu_v = (alu_a[7] == alu_b[7]) && (alu_y[7] != alu_a[7]);
      end
      3'd1: begin
        alu_s = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, alu_c_in};
        alu_y = alu_s[7:0]; alu_c_out = alu_s[8];
        alu_v = (alu_a[7] != alu_b[7]) && (alu_y[7] != alu_a[7]);
      end
      3'd2: alu_y = alu_a & alu_b;
      3'd3: alu_y = alu_a | alu_b;
      3'd4: alu_y = alu_a ^ alu_b;
      3'd5: alu_y = ~alu_a;
      3'd6: alu_y = alu_a << alu_b[2:0];
      default: alu_y = alu_a >> alu_b[2:0];
    endcase
  end

  typedef struct {
    logic [15:0] y;
    logic [3:0]  f;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0, n_pass = 0, n_resp = 0, cyc = 0, hold_n = 0;
  bit          rand_ready = 1'b0, prev_valid = 1'b0, prev_hs = 1'b0;
  logic [15:0] held_y = '0;
  logic [3:0]  flags_m = '0;

  always @(posedge clk) cyc++;

  task automatic check(input logic [31:0] act, input logic [31:0] exp, input string name);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: whole-operand arithmetic on 16-bit values.
  task automatic model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input bit upd, output logic [15:0] y, output int lat);
    logic [16:0] s;
    logic c, v;
    int cnt;
    c = 1'b0; v = 1'b0; y = '0; lat = 3;
    cnt = int'(b[3:0]);
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; y = s[15:0]; c = s[16];
                  v = (a[15] == b[15]) && (y[15] != a[15]); end
      3'd1: begin y = a - b; c = (a >= b); v = (a[15] != b[15]) && (y[15] != a[15]); end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = ~a;
      3'd6: begin y = a << cnt; if (cnt != 0) c = a[16-cnt]; lat = (cnt == 0) ? 1 : 2*cnt + 1; end
      default: begin y = a >> cnt; if (cnt != 0) c = a[cnt-1]; lat = (cnt == 0) ? 1 : 2*cnt + 1; end
    endcase
    if (upd) flags_m = {c, (y == 16'h0), y[15], v};
  endtask

  // Called at a falling edge; returns at the falling edge of the cycle after the handshake.
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input bit upd, input bit expect_resp);
    int t;
    exp_t e;
    int lat;
    t = 0;
    while (!req_ready && t < 300) begin @(negedge clk); t++; end
    check(req_ready, 1, "req_ready_wait");
    if (expect_resp) begin
      model(op, a, b, upd, e.y, lat);
      e.f   = flags_m;
      e.cyc = cyc + lat;
      q.push_back(e);
    end
    req_op = op; req_a = a; req_b = b; req_update_flags = upd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    check(q.size(), 0, "drain");
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_hs) check(req_ready, 1, "req_ready_after_resp");
      if (resp_valid && !prev_valid) begin
        n_resp++;
        check(q.size() != 0, 1, "resp_expected");
        if (q.size() != 0) begin
          e = q.pop_front();
          check(resp_y, e.y, "resp_y");
          check(flags, e.f, "flags");
          check(cyc, e.cyc, "resp_cycle");
        end
      end else if (resp_valid) begin
        check(resp_y, held_y, "held_resp_y");
        check(req_ready, 0, "held_req_ready");
        check(alu_en, 0, "held_alu_en");
      end
      held_y     = resp_y;
      prev_valid = resp_valid;
      if (resp_valid && hold_n > 0) begin
        resp_ready = 1'b0;
        hold_n--;
      end else begin
        resp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      prev_hs = resp_valid && resp_ready;
    end
  end

  initial begin
    int saved;
    logic [15:0] a, b;
    logic [15:0] specials [4];
    specials[0] = 16'h0000; specials[1] = 16'hFFFF;
    specials[2] = 16'h7FFF; specials[3] = 16'h8000;

    repeat (3) @(negedge clk);
    check(resp_valid, 0, "reset_resp_valid");
    check(flags, 0, "reset_flags");
    check(alu_en, 0, "reset_alu_en");
    check(req_ready, 0, "reset_req_ready");
    rst = 1'b0;
    #1 check(req_ready, 1, "idle_req_ready");
    @(negedge clk);

    issue(3'd0, 16'h00FF, 16'h0001, 1'b1, 1'b1);
    check(alu_c_in, 0, "add_w0_cin");
    @(negedge clk);
    check(alu_c_in, 1, "add_w1_cin");
    drain();

    issue(3'd0, 16'h7FFF, 16'h0001, 1'b1, 1'b1);
    issue(3'd1, 16'h0000, 16'h0001, 1'b1, 1'b1);
    issue(3'd4, 16'h5A5A, 16'h5A5A, 1'b0, 1'b1);
    issue(3'd4, 16'h5A5A, 16'h5A5A, 1'b1, 1'b1);
    issue(3'd6, 16'h0081, 16'h0009, 1'b1, 1'b1);
    issue(3'd7, 16'h8001, 16'h0001, 1'b1, 1'b1);
    issue(3'd6, 16'h1234, 16'h0010, 1'b1, 1'b1);
    issue(3'd5, 16'h0F0F, 16'hFFFF, 1'b1, 1'b1);
    drain();

    hold_n = 3;
    issue(3'd3, 16'h1234, 16'h00F0, 1'b1, 1'b1);
    drain();

    issue(3'd6, 16'h0081, 16'h0009, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check(resp_valid, 0, "midop_rst_resp_valid");
    check(flags, 0, "midop_rst_flags");
    check(alu_en, 0, "midop_rst_alu_en");
    rst = 1'b0;
    flags_m = '0;
    #1 check(req_ready, 1, "midop_rst_idle");
    saved = n_resp;
    repeat (40) @(negedge clk);
    check(n_resp, saved, "midop_rst_no_resp");

    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = specials[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) b = specials[$urandom_range(0, 3)];
      issue(3'($urandom_range(0, 7)), a, b, 1'($urandom_range(0, 1)), 1'b1);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-precision sequencer for the 8-bit combinational ALU. It accepts one WORDS×WIDTH-bit operation per request over a valid/ready handshake, then drives the ALU one word per cycle, chaining carry and shift bits between words and repeating single-bit shift passes. It returns the assembled result and maintains the persistent C/Z/N/V status register that the core's branch logic reads. It sits between the execute stage and the ALU. The ALU stays outside this block and is driven through ports.

## Interface
- WIDTH, 8, ALU word width in bits
- WORDS, 2, words per operand; must be at least 2
- SHW, derived as $clog2(WIDTH*WORDS), shift-count width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  3  op code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 LSL, 111 LSR
- req_a, req_b  in  WIDTH*WORDS  operands; for shifts, req_b[SHW-1:0] is the shift count
- req_update_flags  in  1  write the status register when this op completes
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes the result
- resp_y  out  WIDTH*WORDS  result
- flag_c, flag_z, flag_n, flag_v  out  1 each  persistent status register
- alu_a, alu_b  out  WIDTH  ALU operands
- alu_op  out  3  ALU op
- alu_c_in, alu_en, alu_update_flags  out  1 each  ALU controls
- alu_y  in  WIDTH  ALU result
- alu_c_out, alu_v  in  1 each  ALU carry and overflow

## Operation
- **FSM.** The states are IDLE, EXEC and DONE.
  - req_ready = (state==IDLE) && !rst.
  - On a handshake, latch op, operands, update_flags and count. Clear the result register, then go to EXEC. Exception: a shift with count 0 goes straight to DONE with resp_y = req_a.
- **EXEC outputs.** Each cycle drives alu_en=1 and alu_update_flags=1. Outside EXEC, every alu_* output is 0.
- **ADD/SUB.** Words are processed from word 0 (LSW) upward. alu_op = req_op.
  - Word 0 takes c_in = 0 for ADD and c_in = 1 for SUB.
  - Each later word takes c_in = the alu_c_out registered from the previous step.
  - C = final alu_c_out, with SUB C=1 meaning no borrow. V = alu_v of the top word.
- **AND/OR/XOR/NOT.** Processed word by word with c_in = 0. NOT ignores B. C = 0 and V = 0.
- **LSL.** One pass is WORDS steps, LSW first, with alu_b = 1.
  - Word result = alu_y | carry, where carry = previous word's bit WIDTH-1. carry = 0 at the start of each pass.
  - The pass result becomes the A operand of the next pass. Run count passes.
- **LSR.** Same pass structure, processed MSW first.
  - Word result = alu_y | (carry << WIDTH-1), where carry = previous word's bit 0.
- **Shift flags.** C = the last bit shifted out of the full operand, or 0 when count = 0. V = 0.
- **Z and N.** Computed from the assembled result in every case: Z = ~|resp_y and N = resp_y MSB. The per-word ALU Z/N are not used.
- **DONE.**
  - resp_valid=1 and resp_y is held stable until resp_ready; then go to IDLE.
  - The status register updates on entry to DONE, only if update_flags was latched. Otherwise it keeps its old value.
- **Reset.** rst synchronous, including mid-EXEC or mid-DONE:
  - state goes to IDLE and any in-flight op is discarded with no response;
  - resp_valid, resp_y, all flags and all alu_* outputs go to 0.

## Timing
- The handshake happens in cycle T. EXEC runs from T+1 to T+S, where S = WORDS for arith/logic and count×WORDS for shifts. resp_valid rises at T+S+1.
- A shift with count 0 gives resp_valid at T+1.
- The ALU is combinational. alu_y is sampled at the edge ending each EXEC cycle.
- No overlap: req_ready is low from T+1 until the cycle after the resp handshake. Back-to-back throughput is S+2 cycles.
- Flag outputs change in the same cycle that resp_valid rises.

## Structure
- **Shared package alu_pkg** holds:
  - the alu_op_e enum for the 8 op codes;
  - the alu_seq_state_e enum (IDLE/EXEC/DONE);
  - a flags_t struct {c,z,n,v}.
- **No sub-module.** The ALU is instantiated beside this block at the core level. A word counter, a pass counter, the carry bit and the result register all live in this module.

## Test plan
- **16-bit ADD.** ADD 0x00FF+0x0001, update_flags=1 → resp_y=0x0100, C=0, Z=0, N=0, V=0; resp_valid at T+3. Word 1 sees alu_c_in=1.
- **Signed overflow and borrow.** ADD 0x7FFF+0x0001 → 0x8000, N=1, V=1. SUB 0x0000−0x0001 → 0xFFFF, C=0, N=1, V=0.
- **Multi-pass shifts.**
  - LSL 0x0081 by 9 → 0x0200, C=1, resp at T+19.
  - LSR 0x8001 by 1 → 0x4000, C=1.
  - LSL by 0 → resp_y=A, C=0, resp at T+1.
- **Flag gating.** XOR 0x5A5A^0x5A5A with update_flags=0 → resp_y=0x0000 and flags unchanged. The same op with update_flags=1 → Z=1, C=0, V=0.
- **Backpressure.** Hold resp_ready low for 3 cycles in DONE → resp_y stable, req_ready=0, no ALU activity. One cycle after resp_ready, req_ready=1.
- **Reset mid-op.** Assert rst during step 5 of an LSL by 9 → next cycle IDLE, resp_valid=0, flags=0, alu_en=0. No response is ever produced for that op.
